// File: rtl/lane_pair_deser_pkg.sv
// lane_pair_deser_pkg
//   Shared declarations for the two-lane deserializer:
//   - state_e     : output FSM states (EMPTY / FULL)
//   - WIDTH_DEF   : default bits per lane per word
//   - CNT_W_DEF   : default lane-disagreement counter width
//   - bcnt_w()    : width of the shared bit counter for a given WIDTH
package lane_pair_deser_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Bit counter spans 0..WIDTH-1; WIDTH is at least 2 so this is never 0.
    function automatic int bcnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/lane_shift.sv
// lane_shift
//   One lane of LSB-first serial-to-parallel conversion.
//   Ports:
//     CLK, RESETN  : clock, synchronous active-low reset
//     load_i       : shift bit_i in this cycle
//     bit_i        : serial input bit
//     word_next_o  : the WIDTH-bit word formed by the stored bits plus bit_i
//                    (combinational, meaningful on the cycle a word completes)
//   Only WIDTH-1 bits are stored: on the completing cycle the oldest bit is
//   taken straight from storage into the word and then shifted out, so a
//   WIDTH-th storage bit would never be read.
module lane_shift
    import lane_pair_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             load_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_next_o
);

    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-2:0] sr_d;

    // Newest bit enters at the MSB so the first bit received ends in the LSB.
    assign word_next_o = {bit_i, sr_q};

    // Next-state: shift only on a valid bit, otherwise hold the partial word.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = word_next_o[WIDTH-1:1];
        end else begin
            sr_d = sr_q;
        end
    end

    // Shift register state.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sr_q <= {(WIDTH-1){1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/lane_pair_deser.sv
// lane_pair_deser
//   Collects two 1-bit serial lanes into WIDTH-bit words and presents them as
//   one 2*WIDTH-bit word on a valid/ready output. Upstream has no backpressure,
//   so a word completing while the output is stalled is dropped and flagged.
//   Optional feature macro: LANE_PAIR_DESER_MISMATCH_CNT_EN adds a saturating
//   count of valid cycles on which the two lanes disagree.
//   Ports:
//     CLK, RESETN     : clock, synchronous active-low reset
//     I0, I1, I_valid : serial lane bits and their qualifier
//     clear           : synchronous clear of overflow (and mismatch_count)
//     O_data          : {lane-1 word, lane-0 word}
//     O_valid/O_ready : output handshake
//     overflow        : sticky, a completed word was dropped
//     mismatch_count  : lane-disagreement count (macro only)
module lane_pair_deser
    import lane_pair_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               I0,
    input  logic               I1,
    input  logic               I_valid,
    input  logic               clear,
    output logic [2*WIDTH-1:0] O_data,
    output logic               O_valid,
    input  logic               O_ready,
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
    output logic [CNT_W-1:0]   mismatch_count,
`endif
    output logic               overflow
);

    localparam int BW = bcnt_w(WIDTH);

    logic [BW-1:0]      bcnt_q;
    logic [BW-1:0]      bcnt_d;
    state_e             state_q;
    state_e             state_d;
    logic [2*WIDTH-1:0] data_q;
    logic [2*WIDTH-1:0] data_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               done_s;
    logic               accept_s;
    logic [WIDTH-1:0]   word0_s;
    logic [WIDTH-1:0]   word1_s;

    lane_shift #(.WIDTH(WIDTH)) u_lane0 (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .load_i      (I_valid),
        .bit_i       (I0),
        .word_next_o (word0_s)
    );

    lane_shift #(.WIDTH(WIDTH)) u_lane1 (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .load_i      (I_valid),
        .bit_i       (I1),
        .word_next_o (word1_s)
    );

    assign done_s   = I_valid && (bcnt_q == BW'(WIDTH - 1));
    assign accept_s = (state_q == FULL) && O_ready;

    // Shared bit counter: advances on valid bits, wraps when a word completes.
    always_comb begin
        bcnt_d = bcnt_q;
        if (done_s) begin
            bcnt_d = {BW{1'b0}};
        end else if (I_valid) begin
            bcnt_d = bcnt_q + BW'(1'b1);
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Output FSM, output register and sticky overflow next-state.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        case (state_q)
            EMPTY: begin
                if (done_s) begin
                    state_d = FULL;
                    data_d  = {word1_s, word0_s};
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (done_s && accept_s) begin
                    // Old word leaves on this edge, new one replaces it.
                    data_d = {word1_s, word0_s};
                end else if (done_s) begin
                    // Stalled: keep the pending word, lose the new one.
                    ovf_d = 1'b1;
                end else if (accept_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Clear wins over a drop in the same cycle.
        if (clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Counter, FSM, output data and overflow registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            bcnt_q  <= {BW{1'b0}};
            state_q <= EMPTY;
            data_q  <= {(2*WIDTH){1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign O_valid  = (state_q == FULL);
    assign O_data   = data_q;
    assign overflow = ovf_q;

`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
    logic [CNT_W-1:0] mcnt_q;
    logic [CNT_W-1:0] mcnt_d;

    // Saturating disagreement count; clear has priority over increment.
    always_comb begin
        mcnt_d = mcnt_q;
        if (clear) begin
            mcnt_d = {CNT_W{1'b0}};
        end else if (I_valid && (I0 != I1) && (mcnt_q != {CNT_W{1'b1}})) begin
            mcnt_d = mcnt_q + CNT_W'(1'b1);
        end else begin
            mcnt_d = mcnt_q;
        end
    end

    // Disagreement counter register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            mcnt_q <= {CNT_W{1'b0}};
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign mismatch_count = mcnt_q;
`endif

endmodule

// File: tb/tb_lane_pair_deser.sv
// tb_lane_pair_deser
//   Scoreboard bench for lane_pair_deser with WIDTH=4 (CNT_W=2 when the
//   LANE_PAIR_DESER_MISMATCH_CNT_EN macro is defined). Completed words that
//   should be kept are pushed into a queue and popped when the handshake
//   fires; flags and the counter come from a small bench-side model.
module tb_lane_pair_deser;

    localparam int W     = 4;
    localparam int TB_CW = 2;
    localparam int MMAX  = (1 << TB_CW) - 1;

    logic           CLK = 1'b0;
    logic           RESETN = 1'b0;
    logic           I0 = 1'b0;
    logic           I1 = 1'b0;
    logic           I_valid = 1'b0;
    logic           clear = 1'b0;
    logic           O_ready = 1'b0;
    logic [2*W-1:0] O_data;
    logic           O_valid;
    logic           overflow;
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
    logic [TB_CW-1:0] mismatch_count;
`endif

    lane_pair_deser #(
        .WIDTH (W)
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        ,
        .CNT_W (TB_CW)
`endif
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .I0             (I0),
        .I1             (I1),
        .I_valid        (I_valid),
        .clear          (clear),
        .O_data         (O_data),
        .O_valid        (O_valid),
        .O_ready        (O_ready),
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        .mismatch_count (mismatch_count),
`endif
        .overflow       (overflow)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // bench model
    logic [2*W-1:0] sb[$];
    logic           m_full = 1'b0;
    logic           m_ovf  = 1'b0;
    int             m_cnt  = 0;
    int             k      = 0;
    logic [W-1:0]   p0     = '0;
    logic [W-1:0]   p1     = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        k      = 0;
        p0     = '0;
        p1     = '0;
    endtask

    // One clock with the given inputs; model update, then post-edge checks.
    task automatic cyc(input logic v, input logic b0, input logic b1,
                       input logic rdy, input logic clr);
        logic           acc;
        logic           done;
        logic [2*W-1:0] exp;
        I_valid = v;
        I0      = b0;
        I1      = b1;
        O_ready = rdy;
        clear   = clr;
        acc  = m_full && rdy;
        done = 1'b0;
        if (acc) begin
            exp = sb.pop_front();
            check_eq("hs_data", 32'(O_data), 32'(exp));
        end
        if (v) begin
            p0[k] = b0;
            p1[k] = b1;
            if (k == W - 1) begin
                done = 1'b1;
                k    = 0;
            end else begin
                k++;
            end
        end
        if (clr) m_cnt = 0;
        else if (v && (b0 != b1) && (m_cnt < MMAX)) m_cnt++;
        if (done) begin
            if (!m_full || acc) begin
                sb.push_back({p1, p0});
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (acc) begin
            m_full = 1'b0;
        end
        if (clr) m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("valid", 32'(O_valid), 32'(m_full));
        check_eq("ovf", 32'(overflow), 32'(m_ovf));
        if (m_full && sb.size() > 0) check_eq("data_hold", 32'(O_data), 32'(sb[0]));
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        check_eq("mm_cnt", 32'(mismatch_count), 32'(m_cnt));
`endif
    endtask

    // One reset cycle; all outputs must read zero afterwards.
    task automatic do_reset();
        RESETN  = 1'b0;
        I_valid = 1'b1;
        I0      = 1'b1;
        I1      = 1'b0;
        O_ready = 1'b0;
        clear   = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("rst_valid", 32'(O_valid), 32'd0);
        check_eq("rst_data", 32'(O_data), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        check_eq("rst_mm", 32'(mismatch_count), 32'd0);
`endif
        RESETN = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] a0;
        logic [3:0] a1;
        logic [6:0] gv;
        do_reset();
        do_reset();

        // Basic word: expect 8'h4D.
        a0 = 4'b1101;
        a1 = 4'b0100;
        for (int i = 0; i < 4; i++) cyc(1'b1, a0[i], a1[i], 1'b1, 1'b0);
        check_eq("basic_data", 32'(O_data), 32'h4D);
        check_eq("basic_valid", 32'(O_valid), 32'd1);
`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        check_eq("basic_mm", 32'(mismatch_count), 32'd2);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("basic_drain", 32'(O_valid), 32'd0);

        // Stall and drop.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check_eq("stall_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rel_valid", 32'(O_valid), 32'd0);
        check_eq("rel_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("clr_ovf", 32'(overflow), 32'd0);

        // Accept and completion on the same edge: 8'h0F then 8'h3A.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("sim_first", 32'(O_data), 32'h0F);
        a0 = 4'b1010;
        a1 = 4'b0011;
        for (int i = 0; i < 4; i++) cyc(1'b1, a0[i], a1[i], (i == 3), 1'b0);
        check_eq("sim_valid", 32'(O_valid), 32'd1);
        check_eq("sim_data", 32'(O_data), 32'h3A);
        check_eq("sim_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gaps in I_valid: same word as the basic case.
        gv = 7'b1011001;
        a0 = 4'b1101;
        a1 = 4'b0100;
        begin
            int j;
            j = 0;
            for (int i = 0; i < 7; i++) begin
                if (gv[i]) begin
                    cyc(1'b1, a0[j], a1[j], 1'b0, 1'b0);
                    j++;
                end else begin
                    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                end
            end
        end
        check_eq("gap_data", 32'(O_data), 32'h4D);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word: only the new bits appear (8'hF6).
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        a0 = 4'b0110;
        a1 = 4'b1111;
        for (int i = 0; i < 4; i++) cyc(1'b1, a0[i], a1[i], 1'b0, 1'b0);
        check_eq("midrst_data", 32'(O_data), 32'hF6);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));

`ifdef LANE_PAIR_DESER_MISMATCH_CNT_EN
        // Saturation with CNT_W=2, then clear beats a mismatch.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("sat", 32'(mismatch_count), 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("sat_clr", 32'(mismatch_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lane_pair_deser.md
# lane_pair_deser

Downstream consumer of the two-lane 1-bit hierarchy stage (outputs O0/O1 of the Foo/Bar/Baz/Buzz chain). Collects the two serial lanes into parallel WIDTH-bit words, one word per lane, and presents them as one 2*WIDTH-bit word on a valid/ready output. The upstream stage has no backpressure: words that complete while the output is stalled are dropped and flagged. A lane-disagreement counter can optionally be compiled in.

## Interface
- WIDTH, 8: bits per lane per output word; must be at least 2.
- CNT_W, 16: width of the mismatch counter.
- CLK  in  1  rising-edge clock.
- RESETN  in  1  reset; one clock; reset is synchronous and active-low.
- I0  in  1  lane-0 serial bit (from upstream O0).
- I1  in  1  lane-1 serial bit (from upstream O1).
- I_valid  in  1  I0/I1 carry a bit this cycle.
- clear  in  1  synchronous clear of `overflow` and `mismatch_count`.
- O_data  out  2*WIDTH  {lane-1 word, lane-0 word}.
- O_valid  out  1  O_data holds a completed word.
- O_ready  in  1  consumer accepts O_data.
- overflow  out  1  sticky: a completed word was dropped.
- mismatch_count  out  CNT_W  saturating count of valid cycles with I0 != I1. Present only with the macro.

## Operation
- Per-lane shift register plus one shared bit counter `bcnt` (0..WIDTH-1).
- Each I_valid cycle: the lane bits enter the shift registers and `bcnt` increments. The first bit received lands in the LSB.
- Output FSM has two states:
  - EMPTY: O_valid=0.
  - FULL: O_valid=1.
- Word completion (`done`) means I_valid=1 and bcnt==WIDTH-1. On `done`, bcnt wraps to 0.
- FSM transitions:
  - EMPTY and `done` → FULL; the output register loads the assembled word, including the current bits.
  - FULL and O_valid&O_ready and no `done` → EMPTY.
  - FULL and accept and `done` in the same cycle → stay FULL with the new word loaded; no overflow.
  - FULL and no accept and `done` → stay FULL; O_data is unchanged; the new word is discarded; overflow←1.
- O_data is stable while O_valid=1 and O_ready=0.
- Priority for `overflow`: reset, then clear, then set. If clear and a drop occur in the same cycle, overflow=0.
- I_valid=0 leaves bcnt and the shift registers unchanged. Partial words persist indefinitely.
- Reset values: O_valid=0, O_data=0, overflow=0, mismatch_count=0, bcnt=0, shift registers=0, FSM=EMPTY.
- Reset mid-word discards the partial word. Reset while FULL discards the pending word.

## Timing
- Latency: the last bit sampled at edge k gives O_valid=1 and the word on O_data after edge k. There is no combinational path from I0/I1 to O_data.
- O_ready is sampled at the edge. The handshake completes on any edge where O_valid&O_ready=1.
- Sustained throughput is one word per WIDTH valid cycles. Back-to-back words with O_ready tied high produce no drops.
- All outputs are registered.

## Configuration
- Macro: LANE_PAIR_DESER_MISMATCH_CNT_EN.
- Defined:
  - The `mismatch_count` port exists.
  - It increments by 1 on each cycle with I_valid=1 and I0!=I1.
  - It saturates at 2^CNT_W-1.
  - clear has priority over increment.
- Undefined: the port, the counter and the CNT_W usage are removed. All other behaviour is identical.

## Structure
- Package `lane_pair_deser_pkg` holds:
  - the FSM state enum {EMPTY, FULL};
  - the localparam defaults for WIDTH and CNT_W;
  - a function computing the bcnt width, $clog2(WIDTH).
- Sub-module `lane_shift` is one WIDTH-bit LSB-first shift register with a load-enable. It is instantiated twice, once per lane.
- The top level holds bcnt, the FSM, the output register, overflow and the optional counter.

## Test plan
All scenarios use WIDTH=4.
- Basic word:
  - Stimulus: lane-0 bits 1,0,1,1 and lane-1 bits 0,0,1,0 on 4 consecutive valid cycles, O_ready=1.
  - Response: O_valid=1 for one cycle after the 4th edge, O_data=8'h4D.
  - With the macro: mismatch_count=2.
- Stall and drop:
  - Stimulus: O_ready=0, then 8 valid cycles.
  - Response: O_data holds the first word; overflow=1 after the 8th edge.
  - Then O_ready=1 for one cycle: O_valid→0, overflow stays 1.
  - Then clear: overflow→0.
- Simultaneous events:
  - Stimulus: the word is pending and O_ready=1 on the same edge that completes the next word.
  - Response: O_valid stays 1, O_data shows the second word, overflow=0.
- Gaps:
  - Stimulus: I_valid toggled 1,0,0,1,1,0,1.
  - Response: the word completes exactly on the 4th valid bit, with values equal to the gap-free case.
- Reset mid-word:
  - Stimulus: 2 valid bits, then RESETN=0 for 1 cycle, then 4 new bits.
  - Response: the output contains only the 4 new bits. While reset is low, all outputs are 0 on the following edge.
- Saturation (macro on, CNT_W=2):
  - Stimulus: 5 mismatching valid cycles.
  - Response: mismatch_count=3.
  - clear together with a mismatch gives mismatch_count=0.
